// File: rtl/nes_ppu_pkg.sv
// Shared PPU constants and the palette mirror map used by every palette access.
package nes_ppu_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_ADDR   = 3'd6;
    localparam logic [2:0] REG_DATA   = 3'd7;

    localparam logic [5:0] PAL_PAGE = 6'h3F;

    // Sprite backdrop slots 0x10/0x14/0x18/0x1C alias the background ones.
    function automatic logic [4:0] pal_mirror(input logic [4:0] i);
        if (i[4] && (i[1:0] == 2'b00)) begin
            return {1'b0, i[3:0]};
        end
        return i;
    endfunction

endpackage

// File: rtl/nes_ppu_addr_latch.sv
// PPU VRAM address register: PPUADDR two-write latch, PPUCTRL increment step,
// and post-access increment on PPUDATA reads/writes.
module nes_ppu_addr_latch
    import nes_ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_wr,
    input  logic        addr_wr,
    input  logic        data_acc,
    input  logic        status_rd,
    input  logic [7:0]  din,
    output logic [13:0] vram_addr,
    output logic        pal_hit
);

    logic [13:0] vram_addr_q, vram_addr_d;
    logic        w_q, w_d;
    logic        inc32_q, inc32_d;

    always_comb begin
        vram_addr_d = vram_addr_q;
        w_d         = w_q;
        inc32_d     = inc32_q;

        if (ctrl_wr) begin
            inc32_d = din[2];
        end

        if (addr_wr) begin
            if (!w_q) begin
                vram_addr_d[13:8] = din[5:0];
                w_d               = 1'b1;
            end else begin
                vram_addr_d[7:0] = din;
                w_d              = 1'b0;
            end
        end

        // Wraps naturally at 14 bits.
        if (data_acc) begin
            vram_addr_d = vram_addr_q + (inc32_q ? 14'd32 : 14'd1);
        end

        if (status_rd) begin
            w_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vram_addr_q <= 14'd0;
            w_q         <= 1'b0;
            inc32_q     <= 1'b0;
        end else begin
            vram_addr_q <= vram_addr_d;
            w_q         <= w_d;
            inc32_q     <= inc32_d;
        end
    end

    assign vram_addr = vram_addr_q;
    assign pal_hit   = (vram_addr_q[13:8] == PAL_PAGE);

endmodule

// File: rtl/nes_palette_ram_wr.sv
// Writable 32-entry NES palette with CPU register decode and a combinational
// render read port shaped like the palette ROMs it replaces.
module nes_palette_ram_wr
    import nes_ppu_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [2:0]  cpu_reg,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic [4:0]  addr,
    output logic [7:0]  dout,
    output logic [13:0] vram_addr_o
);

    logic [5:0]  mem_q [32];
    logic [5:0]  mem_d [32];
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic [13:0] vram_addr;
    logic        pal_hit;
    logic        wr, rd;
    logic [4:0]  cpu_idx;

    // A write wins over a simultaneous read, so only one increment can occur.
    assign wr      = cpu_we;
    assign rd      = cpu_re & ~cpu_we;
    assign cpu_idx = pal_mirror(vram_addr[4:0]);

    nes_ppu_addr_latch u_addr_latch (
        .clk       (clk),
        .rst       (rst),
        .ctrl_wr   (wr && (cpu_reg == REG_CTRL)),
        .addr_wr   (wr && (cpu_reg == REG_ADDR)),
        .data_acc  ((wr || rd) && (cpu_reg == REG_DATA)),
        .status_rd (rd && (cpu_reg == REG_STATUS)),
        .din       (cpu_din),
        .vram_addr (vram_addr),
        .pal_hit   (pal_hit)
    );

    always_comb begin
        mem_d      = mem_q;
        cpu_dout_d = cpu_dout_q;

        if (wr && (cpu_reg == REG_DATA) && pal_hit) begin
            mem_d[cpu_idx] = cpu_din[5:0];
        end

        if (rd) begin
            if ((cpu_reg == REG_DATA) && pal_hit) begin
                cpu_dout_d = {2'b00, mem_q[cpu_idx]};
            end else begin
                cpu_dout_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= RST_VAL[5:0];
            end
            cpu_dout_q <= 8'h00;
        end else begin
            mem_q      <= mem_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

    assign cpu_dout    = cpu_dout_q;
    assign dout        = {2'b00, mem_q[pal_mirror(addr)]};
    assign vram_addr_o = vram_addr;

endmodule
